slave_fifo: RTL and testbench

Per-channel input buffer of the multi-channel data formatter. It accepts 32-bit words from one upstream channel and stores them in a 64-entry FIFO. It reports free space to the control registers and requests the arbiter once a full package is buffered. On grant, it streams exactly one package of the programmed length. Three instances sit between the channel inputs and the arbiter, each configured by the control-register enable and package-length fields.

---
 rtl/slave_fifo.sv | 151 +++++++++++++++
 tb/tb_slave_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_fifo.sv
// slave_fifo: per-channel input buffer of the multi-channel data formatter.
// Buffers upstream words in a DEPTH-entry FIFO, reports free space, requests the
// arbiter once a full package is stored and, on grant, streams exactly one
// package of the programmed length.
//
// Ports:
//   clk_i, rstn_i          clock (rising edge), asynchronous active-low reset
//   chnl_data_i/valid_i    upstream write word and request
//   chnl_ready_o           FIFO accepts a word this cycle
//   slv_en_i               channel enable
//   slv_pkglen_i           package length code (0:4, 1:8, 2:16, 3..7:32 words)
//   slv_margin_o           free entries (DEPTH - count)
//   slv_req_o              a full package is available
//   a2s_ack_i              arbiter grant pulse
//   slv_data_o/slv_val_o   registered package word and its valid
module slave_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] chnl_data_i,
  input  logic          chnl_valid_i,
  output logic          chnl_ready_o,
  input  logic          slv_en_i,
  input  logic [2:0]    slv_pkglen_i,
  output logic [AW:0]   slv_margin_o,
  output logic          slv_req_o,
  input  logic          a2s_ack_i,
  output logic [DW-1:0] slv_data_o,
  output logic          slv_val_o
);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef enum logic {StIdle, StSend} state_e;

  localparam cnt_t FullCnt = cnt_t'(DEPTH);
  localparam cnt_t CntOne  = cnt_t'(1);
  localparam ptr_t PtrOne  = ptr_t'(1);

  logic [DW-1:0] mem_q [DEPTH];

  state_e        state_q, state_d;
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  cnt_t          count_q, count_d;
  cnt_t          len_q, len_d;
  cnt_t          rem_q, rem_d;
  logic [DW-1:0] data_q, data_d;
  logic          val_q, val_d;

  cnt_t len_dec;
  logic wr_en;
  logic pop;
  logic req;

  // Package length decode; codes above 3 saturate at 32 words.
  always_comb begin
    len_dec = cnt_t'(32);
    case (slv_pkglen_i)
      3'd0:    len_dec = cnt_t'(4);
      3'd1:    len_dec = cnt_t'(8);
      3'd2:    len_dec = cnt_t'(16);
      default: len_dec = cnt_t'(32);
    endcase
  end

  // Ready reflects the count before the edge, so a pop on a full FIFO does not
  // make room for a write in the same cycle.
  assign chnl_ready_o = slv_en_i & (count_q != FullCnt);
  assign wr_en        = chnl_valid_i & chnl_ready_o;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    req     = 1'b0;
    unique case (state_q)
      StIdle: begin
        req = slv_en_i & (count_q >= len_dec);
        if (req && a2s_ack_i) begin
          // Length is frozen for the whole package from here on.
          pop     = 1'b1;
          len_d   = len_dec;
          rem_d   = len_dec - CntOne;
          state_d = StSend;
        end
      end
      StSend: begin
        // Runs to completion regardless of enable or length changes.
        pop   = 1'b1;
        rem_d = rem_q - CntOne;
        if (rem_q == CntOne) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    data_d = pop ? mem_q[rd_ptr_q] : data_q;
    val_d  = pop;
  end

  // Storage is not reset; clearing the pointers and count discards it.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= chnl_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      val_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      val_q    <= val_d;
    end
  end

  assign slv_margin_o = FullCnt - count_q;
  assign slv_req_o    = req;
  assign slv_data_o   = data_q;
  assign slv_val_o    = val_q;

endmodule

// File: tb/tb_slave_fifo.sv
// Testbench for slave_fifo: directed stimulus with a scoreboard. Stimulus moves
// expected package words into exp_q at grant time; a monitor pops and compares
// every word the DUT presents with slv_val_o high.
module tb_slave_fifo;

  logic        clk_i;
  logic        rstn_i;
  logic [31:0] chnl_data_i;
  logic        chnl_valid_i;
  logic        chnl_ready_o;
  logic        slv_en_i;
  logic [2:0]  slv_pkglen_i;
  logic [6:0]  slv_margin_o;
  logic        slv_req_o;
  logic        a2s_ack_i;
  logic [31:0] slv_data_o;
  logic        slv_val_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_q[$]; // words stored in the FIFO, not yet granted
  logic [31:0] exp_q[$];   // granted words awaiting output

  slave_fifo #(.DW(32), .DEPTH(64), .AW(6)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .chnl_data_i  (chnl_data_i),
    .chnl_valid_i (chnl_valid_i),
    .chnl_ready_o (chnl_ready_o),
    .slv_en_i     (slv_en_i),
    .slv_pkglen_i (slv_pkglen_i),
    .slv_margin_o (slv_margin_o),
    .slv_req_o    (slv_req_o),
    .a2s_ack_i    (a2s_ack_i),
    .slv_data_o   (slv_data_o),
    .slv_val_o    (slv_val_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid output word must be the next granted word.
  always @(negedge clk_i) begin
    if (slv_val_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h required no output at %0t", slv_data_o, $time);
      end else begin
        check("pkg_data", slv_data_o, exp_q.pop_front());
      end
    end
  end

  function automatic int len_of(input logic [2:0] code);
    case (code)
      3'd0:    return 4;
      3'd1:    return 8;
      3'd2:    return 16;
      default: return 32;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Entered and left at posedge+1.
  task automatic write_word(input logic [31:0] d);
    chnl_data_i  = d;
    chnl_valid_i = 1'b1;
    @(posedge clk_i);
    if (slv_en_i && (model_q.size() + exp_q.size() < 64)) model_q.push_back(d);
    #1;
    chnl_valid_i = 1'b0;
  endtask

  // Grants one package and checks slv_val_o stays high for exactly LEN cycles.
  // With disturb set, length/enable change and a spurious ack and write occur mid-package.
  task automatic do_pkg(input bit disturb);
    int len;
    len = len_of(slv_pkglen_i);
    check("req_before_ack", 32'(slv_req_o), 32'(1));
    for (int i = 0; i < len; i++) exp_q.push_back(model_q.pop_front());
    a2s_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    a2s_ack_i = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) tick();
      check("val_during_pkg", 32'(slv_val_o), 32'(1));
      if (disturb && i == 2) begin
        slv_pkglen_i = 3'd0;
        slv_en_i     = 1'b0;
        a2s_ack_i    = 1'b1;
        chnl_data_i  = 32'h500;
        chnl_valid_i = 1'b1;
        #1;
        check("ready_after_disable", 32'(chnl_ready_o), 32'(0));
        check("req_in_send", 32'(slv_req_o), 32'(0));
      end
      if (disturb && i == 3) begin
        a2s_ack_i    = 1'b0;
        chnl_valid_i = 1'b0;
      end
    end
    tick();
    check("val_after_pkg", 32'(slv_val_o), 32'(0));
  endtask

  task automatic writer_during_send(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      chnl_data_i  = base + 32'(i);
      chnl_valid_i = 1'b1;
      @(posedge clk_i);
      if (slv_en_i && (model_q.size() + exp_q.size() < 64)) model_q.push_back(base + 32'(i));
      #1;
      check("margin_rw_const", 32'(slv_margin_o), 32'(48));
    end
    chnl_valid_i = 1'b0;
  endtask

  initial begin
    rstn_i       = 1'b1;
    slv_en_i     = 1'b0;
    chnl_valid_i = 1'b0;
    chnl_data_i  = '0;
    a2s_ack_i    = 1'b0;
    slv_pkglen_i = 3'd0;

    // Reset asserted mid-clock, before any edge.
    #2 rstn_i = 1'b0;
    #1;
    check("rst_margin", 32'(slv_margin_o), 32'(64));
    check("rst_val", 32'(slv_val_o), 32'(0));
    check("rst_req", 32'(slv_req_o), 32'(0));
    check("rst_data", slv_data_o, 32'h0);
    check("rst_ready_dis", 32'(chnl_ready_o), 32'(0));
    slv_en_i = 1'b1;
    #1;
    check("rst_ready_en", 32'(chnl_ready_o), 32'(1));
    slv_en_i = 1'b0;
    @(negedge clk_i);
    #2 rstn_i = 1'b1;
    tick();

    // Basic 4-word package.
    slv_en_i     = 1'b1;
    slv_pkglen_i = 3'd0;
    for (int i = 0; i < 3; i++) write_word(32'h10 + 32'(i));
    check("req_3_words", 32'(slv_req_o), 32'(0));
    write_word(32'h13);
    check("req_4_words", 32'(slv_req_o), 32'(1));
    check("margin_60", 32'(slv_margin_o), 32'(60));
    do_pkg(1'b0);
    check("margin_basic_done", 32'(slv_margin_o), 32'(64));
    check("req_basic_done", 32'(slv_req_o), 32'(0));

    // Full FIFO and pointer wrap.
    for (int i = 0; i < 64; i++) write_word(32'h1000 + 32'(i));
    check("ready_full", 32'(chnl_ready_o), 32'(0));
    check("margin_full", 32'(slv_margin_o), 32'(0));
    write_word(32'hDEAD);
    check("margin_65th", 32'(slv_margin_o), 32'(0));
    slv_pkglen_i = 3'd3;
    do_pkg(1'b0);
    check("margin_32", 32'(slv_margin_o), 32'(32));
    for (int i = 0; i < 32; i++) write_word(32'h100 + 32'(i));
    check("margin_refull", 32'(slv_margin_o), 32'(0));
    do_pkg(1'b0);
    do_pkg(1'b0);
    check("margin_drained", 32'(slv_margin_o), 32'(64));

    // Simultaneous write and pop during a 16-word package.
    slv_pkglen_i = 3'd2;
    for (int i = 0; i < 16; i++) write_word(32'h200 + 32'(i));
    fork
      do_pkg(1'b0);
      writer_during_send(32'h300);
    join
    check("margin_after_rw", 32'(slv_margin_o), 32'(48));
    do_pkg(1'b0);
    check("margin_rw_drained", 32'(slv_margin_o), 32'(64));

    // Length and enable changes plus spurious ack during an 8-word package.
    slv_pkglen_i = 3'd1;
    for (int i = 0; i < 8; i++) write_word(32'h400 + 32'(i));
    do_pkg(1'b1);
    check("req_after_disable", 32'(slv_req_o), 32'(0));
    check("margin_no_write", 32'(slv_margin_o), 32'(64));
    check("ready_disabled", 32'(chnl_ready_o), 32'(0));
    slv_en_i = 1'b1;
    #1;
    check("req_reenabled_empty", 32'(slv_req_o), 32'(0));
    tick();

    // Reset after the 3rd word of a 16-word package.
    slv_pkglen_i = 3'd2;
    for (int i = 0; i < 16; i++) write_word(32'h600 + 32'(i));
    check("req_16", 32'(slv_req_o), 32'(1));
    for (int i = 0; i < 3; i++) exp_q.push_back(model_q.pop_front());
    model_q.delete();
    a2s_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    a2s_ack_i = 1'b0;
    tick();
    tick();
    @(negedge clk_i);
    #1 rstn_i = 1'b0;
    #1;
    check("rst_send_val", 32'(slv_val_o), 32'(0));
    check("rst_send_margin", 32'(slv_margin_o), 32'(64));
    check("rst_send_words", 32'(exp_q.size()), 32'(0));
    @(negedge clk_i);
    #1 rstn_i = 1'b1;
    tick();
    slv_pkglen_i = 3'd0;
    for (int i = 0; i < 3; i++) write_word(32'h700 + 32'(i));
    check("req_post_rst_3", 32'(slv_req_o), 32'(0));
    write_word(32'h703);
    check("req_post_rst_4", 32'(slv_req_o), 32'(1));
    do_pkg(1'b0);
    check("margin_final", 32'(slv_margin_o), 32'(64));

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
